aes192_key_expand: RTL and testbench

//  AES-192 key-expansion stage feeding the 13:1 round-key select mux of the aes192dec core.

---
 rtl/aes192_key_pkg.sv | 29 ++
 rtl/aes192_key_if.sv | 59 +++++
 rtl/aes192_key_expand_sbox.sv | 48 ++++
 rtl/aes192_key_expand.sv | 125 ++++++++++++
 tb/tb_aes192_key_expand.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes192_key_pkg.sv
// AES-192 key expansion: shared constants, types and GF(2^8) helper.
// Optional zeroize port is enabled with AES192_KEY_ZEROIZE_EN.
package aes192_key_pkg;

  localparam int NK        = 6;
  localparam int NR        = 12;
  localparam int NUM_RK    = NR + 1;
  localparam int NUM_WORDS = 4 * NUM_RK;
  localparam int WORD_BITS = 32;
  localparam int RK_BITS   = 128;
  localparam int KEY_BITS  = NK * WORD_BITS;
  localparam int RKS_BITS  = NUM_RK * RK_BITS;

  typedef logic [WORD_BITS-1:0] word_t;
  typedef logic [RK_BITS-1:0]   rk_t;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } state_t;

  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes192_key_if.sv
// Key-load handshake and round-key bus of the AES-192 key expander.
// zeroize exists only when AES192_KEY_ZEROIZE_EN is defined.
interface aes192_key_if;
  import aes192_key_pkg::*;

  logic [KEY_BITS-1:0] key_in;
  logic                key_valid;
  logic                key_ready;
  logic                busy;
  logic                done;
  logic                rk_valid;
  logic [RKS_BITS-1:0] round_keys;
`ifdef AES192_KEY_ZEROIZE_EN
  logic                zeroize;

  modport master (
    output key_in,
    output key_valid,
    output zeroize,
    input  key_ready,
    input  busy,
    input  done,
    input  rk_valid,
    input  round_keys
  );

  modport slave (
    input  key_in,
    input  key_valid,
    input  zeroize,
    output key_ready,
    output busy,
    output done,
    output rk_valid,
    output round_keys
  );
`else
  modport master (
    output key_in,
    output key_valid,
    input  key_ready,
    input  busy,
    input  done,
    input  rk_valid,
    input  round_keys
  );

  modport slave (
    input  key_in,
    input  key_valid,
    output key_ready,
    output busy,
    output done,
    output rk_valid,
    output round_keys
  );
`endif

endinterface

// File: rtl/aes192_key_expand_sbox.sv
// Forward AES S-box: multiplicative inverse in GF(2^8) then affine map.
// Purely combinational, one byte per instance.
module aes_sbox
  import aes192_key_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] s
);

  function automatic logic [7:0] gmul(
    input logic [7:0] x,
    input logic [7:0] y
  );
    logic [7:0] p;
    logic [7:0] m;
    p = 8'h00;
    m = x;
    for (int k = 0; k < 8; k++) begin
      if (y[k]) p = p ^ m;
      m = xtime(m);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(
    input logic [7:0] x,
    input int         n
  );
    return (x << n) | (x >> (8 - n));
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // a^254 == a^-1, with 0 mapping to 0
  always_comb begin
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
  end

  assign s = inv ^ rotl(inv, 1) ^ rotl(inv, 2)
           ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;

endmodule

// File: rtl/aes192_key_expand.sv
// AES-192 key schedule: one word per cycle into 52 registers, 13 round keys out.
// Define AES192_KEY_ZEROIZE_EN to add the zeroize clear input.
module aes192_key_expand #(
  parameter int ID     = 0,
  parameter int NUM_RK = 13,
  parameter int WORD_W = 32
) (
  input logic         ap_clk,
  input logic         ap_rst_n,
  aes192_key_if.slave kx
);
  import aes192_key_pkg::*;

  localparam int         NW      = aes192_key_pkg::NUM_WORDS;
  localparam int         NRK     = aes192_key_pkg::NUM_RK;
  localparam logic [5:0] IDX_END = 6'(NW);

  if (ID < 0 || NUM_RK != NRK || WORD_W != WORD_BITS) begin : g_bad_cfg
    $error("aes192_key_expand: unsupported parameters");
  end

  state_t     state;
  state_t     state_nx;
  logic [5:0] idx;
  logic [2:0] phase;
  logic [7:0] rcon;
  word_t      w [NW];
  logic       done_q;
  logic       rkv_q;

  logic       accept;
  logic       zero;
  word_t      prev;
  word_t      rot;
  word_t      sub;
  word_t      t;
  word_t      w_new;

`ifdef AES192_KEY_ZEROIZE_EN
  assign zero = kx.zeroize;
`else
  assign zero = 1'b0;
`endif

  assign kx.busy      = (state == EXPAND);
  assign kx.key_ready = !kx.busy;
  assign kx.done      = done_q;
  assign kx.rk_valid  = rkv_q;
  assign accept       = kx.key_valid && kx.key_ready;

  assign prev = w[idx - 6'd1];
  assign rot  = {prev[23:0], prev[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sub
    aes_sbox u_sbox (
      .a (rot[8*b +: 8]),
      .s (sub[8*b +: 8])
    );
  end

  assign t     = (phase == 3'd0) ? (sub ^ {rcon, 24'h0}) : prev;
  assign w_new = w[idx - 6'd6] ^ t;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = EXPAND;
      EXPAND:  if (idx == IDX_END) state_nx = DONE;
      DONE:    if (accept) state_nx = EXPAND;
      default: state_nx = IDLE;
    endcase
    if (zero) state_nx = IDLE;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int k = 0; k < NW; k++) w[k] <= '0;
      idx    <= '0;
      phase  <= '0;
      rcon   <= '0;
      done_q <= 1'b0;
      rkv_q  <= 1'b0;
    end else if (zero) begin
      for (int k = 0; k < NW; k++) w[k] <= '0;
      idx    <= '0;
      phase  <= '0;
      rcon   <= '0;
      done_q <= 1'b0;
      rkv_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        for (int k = 0; k < NK; k++) begin
          w[k] <= kx.key_in[KEY_BITS-1-WORD_BITS*k -: WORD_BITS];
        end
        idx   <= 6'(NK);
        phase <= '0;
        rcon  <= 8'h01;
        rkv_q <= 1'b0;
      end else if (state == EXPAND) begin
        // idx parks at IDX_END for one edge so done/rk_valid follow w[51]
        if (idx == IDX_END) begin
          done_q <= 1'b1;
          rkv_q  <= 1'b1;
        end else begin
          w[idx] <= w_new;
          idx    <= idx + 6'd1;
          phase  <= (phase == 3'(NK - 1)) ? 3'd0 : phase + 3'd1;
          if (phase == 3'd0) rcon <= xtime(rcon);
        end
      end
    end
  end

  for (genvar r = 0; r < NRK; r++) begin : g_rk
    assign kx.round_keys[RK_BITS*r +: RK_BITS] =
      {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  end

endmodule

// File: tb/tb_aes192_key_expand.sv
// Self-checking bench for aes192_key_expand: FIPS-197 vectors, random keys
// against a table-based reference schedule, and handshake/reset corner cases.
module tb_aes192_key_expand;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;

  aes192_key_if bus ();

  aes192_key_expand #(
    .ID     (0),
    .NUM_RK (13),
    .WORD_W (32)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .kx       (bus)
  );

  always #5 ap_clk = ~ap_clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] sb [256];
  logic [7:0] rc [8];

  typedef struct {
    logic [191:0] key;
    int           wi;
    logic [31:0]  w;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gm_ref(input logic [7:0] a,
                                        input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int k = 0; k < 8; k++) if (b[k]) p = p ^ (16'(a) << k);
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (16'h11b << (k - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] c;
    logic [7:0] s;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gm_ref(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8]
             ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x] = s;
    end
    rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  endtask

  task automatic model(input logic [191:0] k, output logic [1663:0] rks);
    logic [31:0] w [52];
    logic [31:0] t;
    for (int i = 0; i < 6; i++) w[i] = k[191-32*i -: 32];
    for (int i = 6; i < 52; i++) begin
      t = w[i-1];
      if (i % 6 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t = t ^ {rc[i/6-1], 24'h0};
      end
      w[i] = w[i-6] ^ t;
    end
    for (int r = 0; r < 13; r++)
      rks[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic apply_key(input logic [191:0] k);
    @(negedge ap_clk);
    bus.key_in    = k;
    bus.key_valid = 1'b1;
    @(posedge ap_clk);
    #1 bus.key_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 200) begin
      @(posedge ap_clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run_key(input logic [191:0] k, input string nm);
    int cyc;
    apply_key(k);
    wait_done(cyc);
    chk({nm, " latency"}, 128'(cyc), 128'd47);
    chk({nm, " rk_valid"}, 128'(bus.rk_valid), 128'd1);
  endtask

  task automatic cmp_all(input string nm, input logic [1663:0] exp);
    for (int r = 0; r < 13; r++)
      chk($sformatf("%s rk%0d", nm, r),
          bus.round_keys[128*r +: 128], exp[128*r +: 128]);
  endtask

  function automatic logic [191:0] rnd_key();
    return {$urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [191:0]  ka;
    logic [191:0]  kc;
    logic [191:0]  k1;
    logic [191:0]  k2;
    logic [1663:0] e1;
    logic [1663:0] e2;
    logic [127:0]  snap;
    logic [31:0]   got;
    int            cyc;
    int            bad;
    logic          ok;
    logic          saw;

    bus.key_in    = '0;
    bus.key_valid = 1'b0;
`ifdef AES192_KEY_ZEROIZE_EN
    bus.zeroize   = 1'b0;
`endif
    build_sbox();

    ka = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    kc = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    tbl[0]  = '{ka, 6,  32'hfe0c91f7};
    tbl[1]  = '{ka, 12, 32'h4db7b4bd};
    tbl[2]  = '{ka, 51, 32'h01002202};
    tbl[3]  = '{kc, 0,  32'h00010203};
    tbl[4]  = '{kc, 1,  32'h04050607};
    tbl[5]  = '{kc, 2,  32'h08090a0b};
    tbl[6]  = '{kc, 3,  32'h0c0d0e0f};
    tbl[7]  = '{kc, 48, 32'ha4970a33};
    tbl[8]  = '{kc, 49, 32'h1a78dc09};
    tbl[9]  = '{kc, 50, 32'hc418c271};
    tbl[10] = '{kc, 51, 32'he3a41d5d};

    repeat (3) @(posedge ap_clk);
    #1;
    chk("reset ctl", 128'({bus.key_ready, bus.busy, bus.done, bus.rk_valid}),
        128'(4'b1000));
    chk("reset keys", 128'(|bus.round_keys), 128'd0);
    @(negedge ap_clk) ap_rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      if (i == 0 || tbl[i].key !== tbl[i-1].key)
        run_key(tbl[i].key, $sformatf("fips%0d", i));
      got = bus.round_keys[128*(tbl[i].wi/4) + 32*(3-tbl[i].wi%4) +: 32];
      chk($sformatf("fips w%0d", tbl[i].wi), 128'(got), 128'(tbl[i].w));
    end

    snap = bus.round_keys[1536 +: 128];
    ok   = 1'b1;
    repeat (100) begin
      @(posedge ap_clk);
      #1;
      if (bus.rk_valid !== 1'b1 || bus.round_keys[1536 +: 128] !== snap)
        ok = 1'b0;
    end
    chk("persist", 128'(ok), 128'd1);

    k1 = rnd_key();
    k2 = rnd_key();
    model(k1, e1);
    @(negedge ap_clk);
    bus.key_in    = k1;
    bus.key_valid = 1'b1;
    @(posedge ap_clk);
    #1 bus.key_in = ~k1;
    cyc = 0;
    bad = 0;
    while (bus.done !== 1'b1 && cyc < 200) begin
      if (bus.key_ready !== 1'b0) bad++;
      @(posedge ap_clk);
      #1;
      cyc++;
    end
    bus.key_valid = 1'b0;
    chk("hold ready", 128'(bad), 128'd0);
    chk("hold latency", 128'(cyc), 128'd47);
    cmp_all("hold", e1);

    model(k2, e2);
    bus.key_in    = k2;
    bus.key_valid = 1'b1;
    @(posedge ap_clk);
    #1 bus.key_valid = 1'b0;
    chk("b2b drop", 128'({bus.rk_valid, bus.busy}), 128'(2'b01));
    wait_done(cyc);
    chk("b2b latency", 128'(cyc), 128'd47);
    cmp_all("b2b", e2);

    k1 = rnd_key();
    model(k1, e1);
    apply_key(k1);
    repeat (20) @(posedge ap_clk);
    #2 ap_rst_n = 1'b0;
    #1;
    chk("arst ctl", 128'({bus.key_ready, bus.busy, bus.done, bus.rk_valid}),
        128'(4'b1000));
    chk("arst keys", 128'(|bus.round_keys), 128'd0);
    saw = 1'b0;
    repeat (5) begin
      @(posedge ap_clk);
      #1;
      if (bus.done !== 1'b0) saw = 1'b1;
    end
    chk("arst no done", 128'(saw), 128'd0);
    @(negedge ap_clk) ap_rst_n = 1'b1;
    run_key(k1, "rerun");
    cmp_all("rerun", e1);

    for (int n = 0; n < 4; n++) begin
      k1 = rnd_key();
      model(k1, e1);
      run_key(k1, $sformatf("rnd%0d", n));
      cmp_all($sformatf("rnd%0d", n), e1);
    end

`ifdef AES192_KEY_ZEROIZE_EN
    @(negedge ap_clk);
    bus.key_in    = rnd_key();
    bus.key_valid = 1'b1;
    bus.zeroize   = 1'b1;
    @(posedge ap_clk);
    #1;
    bus.key_valid = 1'b0;
    bus.zeroize   = 1'b0;
    chk("zero keys", 128'(|bus.round_keys), 128'd0);
    chk("zero ctl", 128'({bus.key_ready, bus.busy, bus.done, bus.rk_valid}),
        128'(4'b1000));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
